// File: rtl/disp_pkg.sv
// Shared types and constants for the time-shared 7-segment display path.
package disp_pkg;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int BCD_W  = 4 * DIGITS;

    localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SHOW
    } state_e;

    // Active-low segments, bit 7 is the decimal point (kept dark).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] bcd2seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one binary bit per cycle, MSB first.
// done_o is high in the cycle whose closing edge performs the last iteration; bcd_o is valid then.
module bin2bcd_seq
    import disp_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] sh_q;
    logic [BCD_W-1:0] acc_q, acc_d, adj;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        acc_d = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign bcd_o  = acc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            sh_q  <= bin_i;
            acc_q <= '0;
            cnt_q <= CNT_W'(BIN_W);
        end else if (cnt_q != '0) begin
            sh_q  <= {sh_q[BIN_W-2:0], 1'b0};
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/disp_share_ctrl.sv
// Round-robin sharing of a 4-digit 7-segment display among four requesters:
// arbitrate, convert to BCD, hold for HOLD_CYCLES, while scanning digits continuously.
module disp_share_ctrl
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int REFRESH_W   = 20
) (
    input  logic        inClk,
    input  logic        inRstN,
    input  logic [3:0]  inReq,
    input  logic [55:0] inVal,
    output logic [3:0]  outGnt,
    output logic        outBusy,
    output logic [3:0]  dispEn,
    output logic [7:0]  outDisp
);

    localparam int NREQ   = 4;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_e               state_q;
    logic [1:0]           ptr_q;
    logic [NREQ-1:0]      gnt_q;
    logic                 busy_q;
    logic [HOLD_W-1:0]    hold_q;
    logic [BCD_W-1:0]     disp_q;
    logic [REFRESH_W-1:0] ref_q;
    logic [3:0]           en_q;
    logic [7:0]           seg_q;

    logic             found, start, conv_done;
    logic [1:0]       win;
    logic [BIN_W-1:0] win_raw, win_val;
    logic [BCD_W-1:0] conv_bcd;

    // Search upward from the slot after the last winner; the last winner is checked last.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && inReq[ptr_q + 2'(i)]) begin
                found = 1'b1;
                win   = ptr_q + 2'(i);
            end
        end
    end

    assign win_raw = inVal[win*BIN_W +: BIN_W];
    assign win_val = (win_raw > MAX_VAL) ? MAX_VAL : win_raw;
    assign start   = (state_q == ST_IDLE) && found;

    bin2bcd_seq u_bcd (
        .clk_i   (inClk),
        .rst_ni  (inRstN),
        .start_i (start),
        .bin_i   (win_val),
        .bcd_o   (conv_bcd),
        .done_o  (conv_done)
    );

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd3;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            disp_q  <= '0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        gnt_q   <= NREQ'(1) << win;
                        ptr_q   <= win;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    // Whole result lands at once so the scan never shows a half-converted value.
                    if (conv_done) begin
                        disp_q  <= conv_bcd;
                        hold_q  <= '0;
                        state_q <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (hold_q == HOLD_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [1:0] sel;
    logic [3:0] nib;
    logic       blank;
    logic [7:0] seg_d;

    assign sel   = ref_q[REFRESH_W-1 -: 2];
    assign nib   = disp_q[{sel, 2'b00} +: 4];
    assign blank = (sel != 2'd0) && ((disp_q >> {sel, 2'b00}) == '0);
    assign seg_d = blank ? SEG_BLANK : bcd2seg(nib);

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            ref_q <= '0;
            en_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            ref_q <= ref_q + REFRESH_W'(1);
            en_q  <= ~(4'b0001 << sel);
            seg_q <= seg_d;
        end
    end

    assign outGnt  = gnt_q;
    assign outBusy = busy_q;
    assign dispEn  = en_q;
    assign outDisp = seg_q;

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Randomized bench for disp_share_ctrl against a timestamp-based behavioural model.
module tb_disp_share_ctrl;

    localparam int HOLD = 4;
    localparam int RW   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [55:0] val;
    logic [3:0]  outGnt, dispEn;
    logic        outBusy;
    logic [7:0]  outDisp;

    always #5 clk = ~clk;

    disp_share_ctrl #(.HOLD_CYCLES(HOLD), .REFRESH_W(RW)) dut (
        .inClk   (clk),
        .inRstN  (rst_n),
        .inReq   (req),
        .inVal   (val),
        .outGnt  (outGnt),
        .outBusy (outBusy),
        .dispEn  (dispEn),
        .outDisp (outDisp)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] SEGT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int         P10  [4]  = '{1, 10, 100, 1000};

    // Model: n = active edges since reset, ge = edge index of the last grant.
    int         m_n, m_ge, m_ptr, m_pend, m_disp;
    bit         m_have;
    logic [3:0] e_gnt, e_en;
    logic       e_busy;
    logic [7:0] e_seg;

    function automatic logic [7:0] digit_code(input int v, input int d);
        if (d > 0 && v < P10[d]) return 8'hFF;
        return SEGT[(v / P10[d]) % 10];
    endfunction

    task automatic model_reset();
        m_n = 0; m_ge = 0; m_ptr = 3; m_pend = 0; m_disp = 0; m_have = 0;
        e_gnt = 4'h0; e_busy = 1'b0; e_en = 4'hF; e_seg = 8'hFF;
    endtask

    task automatic model_step();
        int sel, v;
        bit idle;
        m_n++;
        idle  = !m_have || (m_n >= m_ge + 15 + HOLD);
        e_gnt = 4'h0;
        if (idle && req != 4'h0) begin
            for (int i = 1; i <= 4; i++) begin
                if (e_gnt == 4'h0 && req[(m_ptr + i) % 4]) begin
                    m_ptr  = (m_ptr + i) % 4;
                    e_gnt  = 4'(1 << m_ptr);
                    v      = int'(val[14*m_ptr +: 14]);
                    m_pend = (v > 9999) ? 9999 : v;
                    m_ge   = m_n;
                    m_have = 1;
                end
            end
        end
        e_busy = m_have && ((m_n - m_ge) < 14 + HOLD);
        sel    = ((m_n - 1) % (1 << RW)) >> (RW - 2);
        e_en   = ~(4'b0001 << sel);
        e_seg  = digit_code(m_disp, sel);
        if (m_have && m_n == m_ge + 14) m_disp = m_pend;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Per-cycle compare against the model.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
            if (!rst_n) model_reset();
            n_checks++;
            if ({outGnt, outBusy, dispEn, outDisp} === {e_gnt, e_busy, e_en, e_seg}) n_pass++;
            else $display("FAIL cycle %0d: got gnt=%b busy=%b en=%b seg=%h, expected gnt=%b busy=%b en=%b seg=%h",
                          cyc, outGnt, outBusy, dispEn, outDisp, e_gnt, e_busy, e_en, e_seg);
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) drive_edge();
    endtask

    task automatic apply_reset();
        drive_edge();
        rst_n = 1'b0;
        req   = 4'h0;
        #1;
        chk("rst_gnt", int'(outGnt), 0);
        chk("rst_busy", int'(outBusy), 0);
        chk("rst_en", int'(dispEn), 'hF);
        chk("rst_seg", int'(outDisp), 'hFF);
        drive_edge();
        drive_edge();
        rst_n = 1'b1;
    endtask

    task automatic scan(output logic [3:0][7:0] c);
        c = '1;
        repeat (16) begin
            @(negedge clk);
            case (dispEn)
                4'b1110: c[0] = outDisp;
                4'b1101: c[1] = outDisp;
                4'b1011: c[2] = outDisp;
                4'b0111: c[3] = outDisp;
                default: ;
            endcase
        end
    endtask

    task automatic chk_scan(input string name, input logic [31:0] exp);
        logic [3:0][7:0] c;
        scan(c);
        chk(name, int'(c), int'(exp));
    endtask

    task automatic wait_gnt(input int maxc, output int k, output int at);
        int i;
        k = -1; at = 0; i = 0;
        while (k < 0 && i < maxc) begin
            @(negedge clk);
            i++;
            if (outGnt != 4'h0) begin
                at = cyc;
                case (outGnt)
                    4'b0001: k = 0;
                    4'b0010: k = 1;
                    4'b0100: k = 2;
                    4'b1000: k = 3;
                    default: k = 9;
                endcase
            end
        end
        if (k < 0) begin
            n_checks++;
            $display("FAIL grant_timeout: no grant within %0d cycles, expected one", maxc);
        end
    endtask

    task automatic one_grant(input logic [3:0] r, input logic [13:0] v, input int exp_k);
        int k, at;
        drive_edge();
        val = {4{v}};
        req = r;
        wait_gnt(5, k, at);
        chk("grant_idx", k, exp_k);
        drive_edge();
        req = 4'h0;
    endtask

    initial begin
        int k, at;
        int ks[5], ts[5];
        int ng;
        rst_n = 1'b0;
        req   = 4'h0;
        val   = '0;

        // Reset and idle scan
        @(negedge clk);
        chk("rst_en0", int'(dispEn), 'hF);
        chk("rst_seg0", int'(outDisp), 'hFF);
        drive_edge();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_en", int'(dispEn), 'hF);
        chk("rel_seg", int'(outDisp), 'hFF);
        @(negedge clk);
        chk("first_en", int'(dispEn), 'hE);
        chk("first_seg", int'(outDisp), 'hC0);
        chk_scan("scan_zero", 32'hFFFFFFC0);

        // 1234 on requester 0
        drive_edge();
        val[13:0] = 14'd1234;
        req = 4'b0001;
        wait_gnt(5, k, at);
        chk("gnt_1234", int'(outGnt), 1);
        drive_edge();
        chk("gnt_pulse", int'(outGnt), 0);
        req = 4'h0;
        idle_wait(20);
        chk_scan("scan_1234", 32'hF9A4B099);

        // All requesting: round-robin order and spacing
        apply_reset();
        req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(40, ks[i], ts[i]);
        end
        req = 4'h0;
        chk("rr_0", ks[0], 0);
        chk("rr_1", ks[1], 1);
        chk("rr_2", ks[2], 2);
        chk("rr_3", ks[3], 3);
        chk("rr_4", ks[4], 0);
        for (int i = 1; i < 5; i++) chk("rr_gap", ts[i] - ts[i-1], 19);

        // Clamp and blanking
        idle_wait(25);
        one_grant(4'b0100, 14'h3FFF, 2);
        idle_wait(20);
        chk_scan("scan_clamp", 32'h90909090);
        one_grant(4'b0010, 14'd7, 1);
        idle_wait(20);
        chk_scan("scan_7", 32'hFFFFFFF8);

        // Reset mid-conversion
        drive_edge();
        val = {4{14'd4321}};
        req = 4'b0001;
        wait_gnt(5, k, at);
        chk("gnt_pre_rst", k, 0);
        drive_edge();
        req = 4'h0;
        idle_wait(5);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt", int'(outGnt), 0);
        chk("mid_busy", int'(outBusy), 0);
        chk("mid_en", int'(dispEn), 'hF);
        chk("mid_seg", int'(outDisp), 'hFF);
        idle_wait(2);
        rst_n = 1'b1;
        chk_scan("scan_after_rst", 32'hFFFFFFC0);
        one_grant(4'b0010, 14'd55, 1);

        // Short request pulse during SHOW is ignored
        idle_wait(25);
        one_grant(4'b0001, 14'd42, 0);
        idle_wait(15);
        req = 4'b0100;
        drive_edge();
        req = 4'h0;
        ng = 0;
        repeat (30) begin
            @(negedge clk);
            if (outGnt != 4'h0) ng++;
        end
        chk("no_late_grant", ng, 0);

        // Randomized traffic
        for (int it = 0; it < 200; it++) begin
            drive_edge();
            req = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            for (int s = 0; s < 4; s++) val[14*s +: 14] = 14'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                drive_edge();
                rst_n = 1'b1;
            end
            idle_wait($urandom_range(0, 24));
        end
        req = 4'h0;
        idle_wait(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_share_ctrl.md
# disp_share_ctrl

Time-shares the board's 4-digit common-anode 7-segment display among four binary requesters. A round-robin arbiter grants one requester at a time. The granted 14-bit value goes through an iterative double-dabble converter, one bit per cycle, and is shown for a programmable hold time while the digits are scanned continuously. The block sits between the application's value sources and the display pins and sequences the conversion and scan datapath.

## Interface
- HOLD_CYCLES, 50_000_000: cycles a granted value stays displayed before the next arbitration; minimum 1.
- REFRESH_W, 20: refresh counter width; digit select = counter[REFRESH_W-1:REFRESH_W-2].
- inClk  in  1  system clock; single clock domain.
- inRstN  in  1  asynchronous, active-low reset.
- inReq  in  4  level requests, bit k = requester k.
- inVal  in  56  requester values, inVal[14k+13:14k] = requester k, unsigned.
- outGnt  out  4  one-hot grant pulse, one cycle wide.
- outBusy  out  1  high in CONVERT and SHOW.
- dispEn  out  4  digit enables, active-low; 4'b1110 = digit 0 (ones).
- outDisp  out  8  segments, active-low; bit 7 = dp, always 1.

## Operation
- FSM states: IDLE, CONVERT, SHOW.
- IDLE with inReq == 0: stay in IDLE; the display keeps its last value.
- IDLE with inReq != 0: grant the first set bit searching from ptr+1 mod 4 upward.
  - Latch that requester's value, clamped to 9999 if above 9999.
  - Pulse outGnt[k], set ptr = k, go to CONVERT.
- CONVERT: 14 iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts in the next value bit, MSB first.
  - After the 14th iteration, copy the 16-bit BCD result into the display register in one atomic update, so no partial values are ever visible.
  - Go to SHOW and clear the hold counter.
- SHOW: count HOLD_CYCLES cycles, then go to IDLE. Requests arriving during CONVERT or SHOW are not latched; they are seen only in IDLE.
- Scan: the refresh counter free-runs in every state. Digit select 0..3 maps to dispEn 1110/1101/1011/0111 and to BCD nibble [3:0]/[7:4]/[11:8]/[15:12].
- Leading-zero blanking: digit d (d = 1..3) outputs 8'hFF when it and all higher nibbles are 0. Digit 0 is never blanked.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF. Non-BCD nibbles are unreachable and output FF.
- Reset mid-operation: the FSM returns to IDLE immediately and any in-flight conversion is discarded.
- Reset values: outGnt=0, outBusy=0, dispEn=4'b1111, outDisp=8'hFF, ptr=3 (so requester 0 wins first), display register=0, refresh counter=0, FSM=IDLE.

## Timing
- Edge E: FSM in IDLE with a request present. At E the grant is registered.
  - outGnt visible in cycle E+1.
  - outBusy is high from E+1 through the last SHOW cycle.
- The display register updates at edge E+14.
- SHOW lasts exactly HOLD_CYCLES cycles. IDLE is re-entered at edge E+14+HOLD_CYCLES.
- The earliest next grant is at edge E+15+HOLD_CYCLES, so there is one idle cycle minimum between grants.
- dispEn and outDisp are registered from the same digit select. Both change on the same edge, one cycle after the select bits change.
- A digit change in the display register appears on the pins within one cycle of being scanned.
- A request dropped before the arbitration edge is ignored. A held request is re-served only after the pointer rotates past it.

## Structure
- Package disp_pkg holds:
  - the FSM state enum;
  - SEG_0..SEG_9 and SEG_BLANK constants;
  - the DIGITS=4 and BIN_W=14 constants;
  - a function mapping BCD nibble to segment code.
- Sub-module bin2bcd_seq: the iterative double-dabble core.
  - Ports: clock, reset, start, 14-bit bin, 16-bit bcd, done pulse.
  - It is also reusable by other display paths.
- Top level holds the arbiter, FSM, hold counter, refresh counter and scan/blanking logic.

## Test plan
- Reset, then release with no requests. Required: dispEn=1111, outDisp=FF for one cycle. Then digit 0 scans C0 and digits 1-3 scan FF.
- inReq=0001, inVal[13:0]=1234. Required:
  - outGnt=0001 for one cycle;
  - display register = 16'h1234 exactly 14 cycles later;
  - scanned codes (digit 0..3) = 99, B0, A4, F9.
- inReq=1111 held, HOLD_CYCLES=4. Required: grant order 0,1,2,3,0, with exactly 19 cycles between successive grant pulses.
- inVal=16383 (14'h3FFF). Required: display register = 16'h9999. inVal=7 gives digit 0 = F8 and digits 1-3 = FF.
- inRstN asserted during CONVERT (cycle E+6). Required: outputs return to their reset values asynchronously and the display register stays 0. After release, a new request is granted normally.
- Requester 2 pulses inReq for one cycle while the FSM is in SHOW. Required: no grant to requester 2, and outGnt stays 0 after returning to IDLE.
